// File: rtl/rf_write_sequencer_if.sv
// Bundles the ALU and load write-back request channels, the register-file
// write port, the occupancy report and the forwarding lookup of
// rf_write_sequencer. The sequencer connects through the slave modport and
// its driver connects through the master modport.
interface rf_write_sequencer_if #(
  parameter int CNT_WIDTH = 3
);
  logic                 alu_valid;
  logic                 alu_ready;
  logic [4:0]           alu_waddr;
  logic [31:0]          alu_wdata;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [4:0]           mem_waddr;
  logic [31:0]          mem_wdata;
  logic                 rf_wen;
  logic [4:0]           rf_waddr;
  logic [31:0]          rf_wdata;
  logic [CNT_WIDTH-1:0] occupancy;
  logic [4:0]           fwd_raddr;
  logic                 fwd_hit;
  logic [31:0]          fwd_data;

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    input  fwd_raddr,
    output alu_ready, mem_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output occupancy,
    output fwd_hit, fwd_data
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    output fwd_raddr,
    input  alu_ready, mem_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  occupancy,
    input  fwd_hit, fwd_data
  );
endinterface

// File: rtl/rf_write_sequencer.sv
// Register-file write sequencer.
//
// Write-back requests come from two producers: the load unit (mem_*) and the
// ALU (alu_*). The load unit has fixed priority. Accepted requests go into a
// DEPTH-entry FIFO. The head entry drains into the registered rf_* write port
// once per cycle. Requests that target r0 still complete their handshake, but
// they are dropped and never enter the FIFO.
//
// Optional feature macro: RF_WRITE_SEQ_FWD_EN
//   defined   -> fwd_hit/fwd_data report the youngest pending write to
//                fwd_raddr. The search covers the FIFO first and then the
//                rf_* output register.
//   undefined -> fwd_hit/fwd_data are tied to zero.
module rf_write_sequencer #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2,
  parameter int CNT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_write_sequencer_if.slave   bus
);

  logic [4:0]           addr_mem_r [DEPTH];
  logic [31:0]          data_mem_r [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 rf_wen_r;
  logic [4:0]           rf_waddr_r;
  logic [31:0]          rf_wdata_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [4:0]           push_addr_s;
  logic [31:0]          push_data_s;
  logic                 fwd_hit_s;
  logic [31:0]          fwd_data_s;

  // Full and empty come only from the registered count, so the ready outputs
  // never depend on a pop in the same cycle.
  assign full_s  = (count_r == CNT_WIDTH'(DEPTH));
  assign empty_s = (count_r == {CNT_WIDTH{1'b0}});
  assign pop_s   = !empty_s;

  assign bus.mem_ready = !full_s;
  assign bus.alu_ready = !full_s && !bus.mem_valid;

  // Pick at most one request to enqueue. A load has priority, and r0 targets
  // are dropped after the handshake.
  always_comb begin
    push_s      = 1'b0;
    push_addr_s = 5'd0;
    push_data_s = 32'd0;
    if (bus.mem_valid && !full_s) begin
      push_addr_s = bus.mem_waddr;
      push_data_s = bus.mem_wdata;
      push_s      = (bus.mem_waddr != 5'd0);
    end else if (bus.alu_valid && !full_s) begin
      push_addr_s = bus.alu_waddr;
      push_data_s = bus.alu_wdata;
      push_s      = (bus.alu_waddr != 5'd0);
    end else begin
      push_s      = 1'b0;
    end
  end

  // FIFO storage. The entries need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= push_addr_s;
      data_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Pointers, occupancy and the registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_WIDTH{1'b0}};
      rd_ptr_r   <= {PTR_WIDTH{1'b0}};
      count_r    <= {CNT_WIDTH{1'b0}};
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
      end
      if (pop_s) begin
        rf_wen_r   <= 1'b1;
        rf_waddr_r <= addr_mem_r[rd_ptr_r];
        rf_wdata_r <= data_mem_r[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + PTR_WIDTH'(1);
      end else begin
        rf_wen_r   <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef RF_WRITE_SEQ_FWD_EN
  // Forwarding lookup. The output register has the lowest priority. FIFO
  // entries are then scanned from oldest to youngest, so the youngest match
  // overrides any older one.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'd0;
    if (bus.fwd_raddr != 5'd0) begin
      if (rf_wen_r && (rf_waddr_r == bus.fwd_raddr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = rf_wdata_r;
      end else begin
        fwd_hit_s  = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_WIDTH'(i) < count_r) &&
            (addr_mem_r[rd_ptr_r + PTR_WIDTH'(i)] == bus.fwd_raddr)) begin
          fwd_hit_s  = 1'b1;
          fwd_data_s = data_mem_r[rd_ptr_r + PTR_WIDTH'(i)];
        end else begin
          fwd_hit_s  = fwd_hit_s;
        end
      end
    end else begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = 32'd0;
    end
  end
`else
  logic unused_fwd_raddr_s;
  assign unused_fwd_raddr_s = ^bus.fwd_raddr;
  assign fwd_hit_s          = 1'b0;
  assign fwd_data_s         = 32'd0;
`endif

  assign bus.rf_wen    = rf_wen_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.occupancy = count_r;
  assign bus.fwd_hit   = fwd_hit_s;
  assign bus.fwd_data  = fwd_data_s;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Directed testbench for rf_write_sequencer.
//
// The bench keeps a reference FIFO queue. An entry is pushed onto it when the
// bench drives a request that the reference says is accepted. The entry is
// popped and compared when the DUT issues a register-file write.
module tb_rf_write_sequencer;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  ent_t        mq[$];
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic        exp_wen;

  rf_write_sequencer_if #(.CNT_WIDTH(3)) bus ();

  rf_write_sequencer #(.DEPTH(4), .PTR_WIDTH(2), .CNT_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference forwarding result: youngest queued entry first, then the
  // output register.
  task automatic fwd_model(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
`ifdef RF_WRITE_SEQ_FWD_EN
    if (a != 5'd0) begin
      if (exp_wen && last_a == a) begin
        h = 1'b1;
        d = last_d;
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
    end
`endif
  endtask

  // Check everything that is visible between clock edges.
  task automatic check_state();
    logic        h;
    logic [31:0] d;
    chk("rf_wen", {31'd0, bus.rf_wen}, {31'd0, exp_wen});
    chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, last_a});
    chk("rf_wdata", bus.rf_wdata, last_d);
    chk("occupancy", {29'd0, bus.occupancy}, 32'(mq.size()));
    fwd_model(bus.fwd_raddr, h, d);
    chk("fwd_hit", {31'd0, bus.fwd_hit}, {31'd0, h});
    chk("fwd_data", bus.fwd_data, d);
  endtask

  // Run one clock cycle: drive the requests, check the ready outputs, update
  // the reference at the edge, then check the state after the edge.
  task automatic tick(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic exp_mr;
    logic exp_ar;
    logic push;
    ent_t e;
    bus.mem_valid = mv;
    bus.mem_waddr = ma;
    bus.mem_wdata = md;
    bus.alu_valid = av;
    bus.alu_waddr = aa;
    bus.alu_wdata = ad;
    #1;
    exp_mr = (mq.size() != 4);
    exp_ar = exp_mr && !mv;
    chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, exp_mr});
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, exp_ar});
    push = 1'b0;
    if (mv && exp_mr) begin
      push = (ma != 5'd0);
      e = '{a: ma, d: md};
    end else if (av && exp_ar) begin
      push = (aa != 5'd0);
      e = '{a: aa, d: ad};
    end
    @(posedge clk);
    if (mq.size() > 0) begin
      ent_t h;
      h = mq.pop_front();
      exp_wen = 1'b1;
      last_a = h.a;
      last_d = h.d;
    end else begin
      exp_wen = 1'b0;
    end
    if (push) mq.push_back(e);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    check_state();
  endtask

  task automatic idle();
    tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_wen = 1'b0;
    last_a = 5'd0;
    last_d = 32'd0;
    check_state();
    chk("mem_ready_after_rst", {31'd0, bus.mem_ready}, 32'd1);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    exp_wen = 1'b0;
    last_a = 5'd0;
    last_d = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_waddr = 5'd0;
    bus.mem_wdata = 32'd0;
    bus.alu_valid = 1'b0;
    bus.alu_waddr = 5'd0;
    bus.alu_wdata = 32'd0;
    bus.fwd_raddr = 5'd0;

    do_reset();

    // Single ALU write: occupancy rises for one cycle, then the write issues.
    bus.fwd_raddr = 5'd5;
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678);
    idle();
    chk("single_issue_addr", {27'd0, bus.rf_waddr}, 32'd5);
    idle();

    // Conflict: the load wins and the ALU retries in the next cycle.
    bus.fwd_raddr = 5'd3;
    tick(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h00000001);
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h00000001);
    idle();
    idle();

    // Back-to-back traffic on both ports. This wraps the pointers several times.
    for (int i = 0; i < 14; i++) begin
      bus.fwd_raddr = 5'(i % 31 + 1);
      tick((i % 3) != 2, 5'(i % 31 + 1), 32'hC0DE0000 + 32'(i),
           1'b1, 5'(30 - i), 32'hA1000000 + 32'(i));
    end
    idle();
    idle();

    // Writes to r0 complete the handshake but are never enqueued.
    bus.fwd_raddr = 5'd0;
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF);
    tick(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd9, 32'h9);
    idle();
    idle();

    // A reset in the middle of traffic discards pending writes.
    tick(1'b1, 5'd10, 32'h10, 1'b0, 5'd0, 32'd0);
    tick(1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'd0);
    do_reset();
    idle();
    idle();

    // Forwarding: two writes to r7. The youngest one must be reported.
    bus.fwd_raddr = 5'd7;
    tick(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0);
    tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
    bus.fwd_raddr = 5'd0;
    #1;
    chk("fwd_r0_hit", {31'd0, bus.fwd_hit}, 32'd0);
    bus.fwd_raddr = 5'd7;
    idle();
    idle();

    chk("drained", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
